// File: rtl/pipeline_step_ctrl.sv
// Run/step/halt controller producing the global pipeline step enable; optional cycle counter under PIPELINE_STEP_CYCLE_COUNTER_EN.
// Latency: commands take effect on the next i_clk edge; o_step is a pure decode of the registered state.
// Backpressure: none; commands not accepted in the current state are discarded, never queued.
module pipeline_step_ctrl (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_run_cmd,
  input  logic        i_step_cmd,
  input  logic [7:0]  i_step_count,
  input  logic        i_stop_cmd,
  input  logic        i_clear_cmd,
  input  logic        i_halt_wb,
  output logic        o_step,
  output logic [1:0]  o_state,
  output logic        o_halted,
  output logic        o_step_done,
  output logic [31:0] o_cycle_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_STEP   = 2'b10,
    ST_HALTED = 2'b11
  } state_t;

  state_t     state;
  logic [7:0] burst_cnt;

  // Enable is a decode of the state register only, so reset drops it immediately
  assign o_step  = (state == ST_RUN) || (state == ST_STEP);
  assign o_state = state;

  // Control FSM with registered halted / step-done outputs
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      burst_cnt   <= 8'd0;
      o_halted    <= 1'b0;
      o_step_done <= 1'b0;
    end else begin
      o_step_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_run_cmd) begin
            state <= ST_RUN;
          end else if (i_step_cmd) begin
            state     <= ST_STEP;
            burst_cnt <= (i_step_count == 8'd0) ? 8'd1 : i_step_count;
          end
        end
        ST_RUN: begin
          // Halt from writeback outranks a concurrent stop request
          if (i_halt_wb) begin
            state    <= ST_HALTED;
            o_halted <= 1'b1;
          end else if (i_stop_cmd) begin
            state <= ST_IDLE;
          end
        end
        ST_STEP: begin
          burst_cnt <= burst_cnt - 8'd1;
          if (i_halt_wb) begin
            state    <= ST_HALTED;
            o_halted <= 1'b1;
          end else if (burst_cnt == 8'd1) begin
            state       <= ST_IDLE;
            o_step_done <= 1'b1;
          end else if (i_stop_cmd) begin
            state <= ST_IDLE;
          end
        end
        ST_HALTED: begin
          if (i_clear_cmd) begin
            state    <= ST_IDLE;
            o_halted <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef PIPELINE_STEP_CYCLE_COUNTER_EN
  logic [31:0] cycle_cnt_q;

  // Count enabled cycles; clear wins over increment and the count saturates
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      cycle_cnt_q <= 32'd0;
    end else if (i_clear_cmd) begin
      cycle_cnt_q <= 32'd0;
    end else if (o_step && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
      cycle_cnt_q <= cycle_cnt_q + 32'd1;
    end
  end

  assign o_cycle_count = cycle_cnt_q;
`else
  assign o_cycle_count = 32'd0;
`endif

endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// Directed table-driven bench for pipeline_step_ctrl plus hand sequences for run/stop, async reset and saturation.
// Latency: each vector is applied for one i_clk cycle and checked 1 time unit after the rising edge.
// Backpressure: not applicable; the bench drives single-cycle command pulses.
module tb_pipeline_step_ctrl;

`ifdef PIPELINE_STEP_CYCLE_COUNTER_EN
  localparam logic CNT_EN = 1'b1;
`else
  localparam logic CNT_EN = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_run_cmd = 1'b0;
  logic        i_step_cmd = 1'b0;
  logic [7:0]  i_step_count = 8'd0;
  logic        i_stop_cmd = 1'b0;
  logic        i_clear_cmd = 1'b0;
  logic        i_halt_wb = 1'b0;
  logic        o_step;
  logic [1:0]  o_state;
  logic        o_halted;
  logic        o_step_done;
  logic [31:0] o_cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_step_ctrl dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_run_cmd    (i_run_cmd),
    .i_step_cmd   (i_step_cmd),
    .i_step_count (i_step_count),
    .i_stop_cmd   (i_stop_cmd),
    .i_clear_cmd  (i_clear_cmd),
    .i_halt_wb    (i_halt_wb),
    .o_step       (o_step),
    .o_state      (o_state),
    .o_halted     (o_halted),
    .o_step_done  (o_step_done),
    .o_cycle_count(o_cycle_count)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        run;
    logic        step;
    logic [7:0]  n;
    logic        stop;
    logic        clear;
    logic        halt;
    logic [1:0]  st;
    logic        stp;
    logic        hlt;
    logic        done;
    logic [31:0] cnt;
  } vec_t;

  localparam int NVEC = 28;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ecnt(input logic [31:0] full);
    return CNT_EN ? full : 32'd0;
  endfunction

  task automatic drive(input logic r, input logic s, input logic [7:0] n,
                       input logic sp, input logic c, input logic h);
    i_run_cmd    = r;
    i_step_cmd   = s;
    i_step_count = n;
    i_stop_cmd   = sp;
    i_clear_cmd  = c;
    i_halt_wb    = h;
  endtask

  // One clock with the given inputs, then inputs back to idle, sampled after the edge
  task automatic cyc(input logic r, input logic s, input logic [7:0] n,
                     input logic sp, input logic c, input logic h);
    drive(r, s, n, sp, c, h);
    @(posedge i_clk);
    #1;
    drive(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_all(input string tag, input logic [1:0] st, input logic stp,
                         input logic hlt, input logic dn, input logic [31:0] cnt);
    chk({tag, ".state"},  {30'd0, o_state}, {30'd0, st});
    chk({tag, ".step"},   {31'd0, o_step}, {31'd0, stp});
    chk({tag, ".halted"}, {31'd0, o_halted}, {31'd0, hlt});
    chk({tag, ".done"},   {31'd0, o_step_done}, {31'd0, dn});
    chk({tag, ".count"},  o_cycle_count, ecnt(cnt));
  endtask

  initial begin
    int step_hi;
    //          run  stp  n     stop clr  halt   st     stp  hlt  dn   cnt
    vecs[0]  = {1'b0,1'b1,8'd3,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b0,32'd0};
    vecs[1]  = {1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b0,32'd1};
    vecs[2]  = {1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b0,32'd2};
    vecs[3]  = {1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b1,32'd3};
    vecs[4]  = {1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0,32'd3};
    vecs[5]  = {1'b0,1'b1,8'd0,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b0,32'd3};
    vecs[6]  = {1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b1,32'd4};
    vecs[7]  = {1'b1,1'b1,8'd2,1'b0,1'b0,1'b0, 2'b01,1'b1,1'b0,1'b0,32'd4};
    vecs[8]  = {1'b0,1'b1,8'd5,1'b0,1'b0,1'b0, 2'b01,1'b1,1'b0,1'b0,32'd5};
    vecs[9]  = {1'b0,1'b0,8'd0,1'b1,1'b0,1'b1, 2'b11,1'b0,1'b1,1'b0,32'd6};
    vecs[10] = {1'b1,1'b0,8'd0,1'b0,1'b0,1'b0, 2'b11,1'b0,1'b1,1'b0,32'd6};
    vecs[11] = {1'b0,1'b1,8'd2,1'b0,1'b0,1'b0, 2'b11,1'b0,1'b1,1'b0,32'd6};
    vecs[12] = {1'b0,1'b0,8'd0,1'b1,1'b0,1'b0, 2'b11,1'b0,1'b1,1'b0,32'd6};
    vecs[13] = {1'b0,1'b0,8'd0,1'b0,1'b1,1'b0, 2'b00,1'b0,1'b0,1'b0,32'd0};
    vecs[14] = {1'b0,1'b1,8'd5,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b0,32'd0};
    vecs[15] = {1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b0,32'd1};
    vecs[16] = {1'b0,1'b0,8'd0,1'b0,1'b0,1'b1, 2'b11,1'b0,1'b1,1'b0,32'd2};
    vecs[17] = {1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 2'b11,1'b0,1'b1,1'b0,32'd2};
    vecs[18] = {1'b0,1'b0,8'd0,1'b0,1'b1,1'b0, 2'b00,1'b0,1'b0,1'b0,32'd0};
    vecs[19] = {1'b0,1'b1,8'd4,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b0,32'd0};
    vecs[20] = {1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 2'b10,1'b1,1'b0,1'b0,32'd1};
    vecs[21] = {1'b0,1'b0,8'd0,1'b1,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0,32'd2};
    vecs[22] = {1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0,32'd2};
    vecs[23] = {1'b0,1'b0,8'd0,1'b0,1'b1,1'b0, 2'b00,1'b0,1'b0,1'b0,32'd0};
    vecs[24] = {1'b1,1'b0,8'd0,1'b0,1'b0,1'b0, 2'b01,1'b1,1'b0,1'b0,32'd0};
    vecs[25] = {1'b0,1'b0,8'd0,1'b0,1'b1,1'b0, 2'b01,1'b1,1'b0,1'b0,32'd0};
    vecs[26] = {1'b0,1'b0,8'd0,1'b0,1'b0,1'b0, 2'b01,1'b1,1'b0,1'b0,32'd1};
    vecs[27] = {1'b0,1'b0,8'd0,1'b1,1'b0,1'b0, 2'b00,1'b0,1'b0,1'b0,32'd2};

    // Reset state
    #12;
    chk_all("reset", 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
    i_reset_n = 1'b1;

    // Table-driven vectors
    for (int i = 0; i < NVEC; i++) begin
      cyc(vecs[i].run, vecs[i].step, vecs[i].n, vecs[i].stop, vecs[i].clear, vecs[i].halt);
      chk_all($sformatf("vec%0d", i), vecs[i].st, vecs[i].stp, vecs[i].hlt, vecs[i].done, vecs[i].cnt);
    end

    // Run then stop: ten enabled cycles
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    step_hi = 0;
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    if (o_step) step_hi++;
    for (int k = 0; k < 9; k++) begin
      cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      if (o_step) step_hi++;
    end
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    if (o_step) step_hi++;
    chk("runstop.step_cycles", step_hi, 32'd10);
    chk_all("runstop", 2'b00, 1'b0, 1'b0, 1'b0, 32'd10);

    // Async reset mid-run: outputs drop before the next edge
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("arst.pre_state", {30'd0, o_state}, 32'd1);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk_all("arst", 2'b00, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    // First command after release is taken on the first edge
    cyc(1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
    chk_all("post_rst", 2'b10, 1'b1, 1'b0, 1'b0, 32'd0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk_all("post_rst_done", 2'b00, 1'b0, 1'b0, 1'b1, 32'd2);

    // Saturation of the cycle counter
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge i_clk);
`ifdef PIPELINE_STEP_CYCLE_COUNTER_EN
    force dut.cycle_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.cycle_cnt_q;
`endif
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("sat.first", o_cycle_count, CNT_EN ? 32'hFFFF_FFFF : 32'd0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
    chk("sat.hold", o_cycle_count, CNT_EN ? 32'hFFFF_FFFF : 32'd0);
    chk("sat.state", {30'd0, o_state}, 32'd1);
    cyc(1'b0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0);
    chk("sat.stop", o_cycle_count, CNT_EN ? 32'hFFFF_FFFF : 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_step_ctrl.md
PIPELINE_STEP_CTRL -- requirements
Module: pipeline_step_ctrl

Interface
REQ-001 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-002 i_clk  input  1  rising-edge clock for all state.
REQ-003 i_reset_n  input  1  asynchronous active-low reset.
REQ-004 i_run_cmd  input  1  single-cycle pulse, start continuous execution.
REQ-005 i_step_cmd  input  1  single-cycle pulse, start a burst of stepped cycles.
REQ-006 i_step_count  input  8  burst length sampled with i_step_cmd; 0 SHALL be treated as 1.
REQ-007 i_stop_cmd  input  1  single-cycle pulse, stop continuous execution.
REQ-008 i_clear_cmd  input  1  single-cycle pulse, leave HALTED and clear the cycle counter.
REQ-009 i_halt_wb  input  1  halt instruction reached writeback, from the pipeline.
REQ-010 o_step  output  1  global enable driven to every pipeline register's i_step.
REQ-011 o_state  output  2  FSM state: IDLE=00, RUN=01, STEP=10, HALTED=11.
REQ-012 o_halted  output  1  high while in HALTED.
REQ-013 o_step_done  output  1  one-cycle pulse when a step burst completes without halting.
REQ-014 o_cycle_count  output  32  count of cycles with o_step=1.

Function
REQ-015 o_step SHALL be decoded from the registered state only: 1 in RUN and STEP, 0 in IDLE and HALTED.
- No combinational path from any input to o_step.
REQ-016 In IDLE, i_run_cmd SHALL move to RUN on the next edge.
- Else i_step_cmd SHALL move to STEP and load the burst counter with max(i_step_count,1).
- i_run_cmd has priority when both are high.
REQ-017 In RUN, i_halt_wb=1 SHALL move to HALTED.
- Else i_stop_cmd=1 SHALL move to IDLE.
- Halt wins when both are high.
- i_run_cmd and i_step_cmd are ignored in RUN.
REQ-018 In STEP, the burst counter SHALL decrement every cycle.
- i_halt_wb=1 SHALL move to HALTED.
- Else a counter value of 1 SHALL move to IDLE and pulse o_step_done for the first IDLE cycle.
- Else i_stop_cmd=1 SHALL abort to IDLE with no o_step_done.
- o_step SHALL be high for exactly N cycles of an uninterrupted N-cycle burst.
REQ-019 In HALTED, only i_clear_cmd SHALL act: move to IDLE.
- All other commands are dropped; there is no queuing of commands.
REQ-020 Commands arriving in a state that does not accept them SHALL be discarded, not held.
REQ-021 o_cycle_count SHALL increment by 1 on each edge where o_step=1.
- It SHALL saturate at 0xFFFFFFFF with no wrap.
REQ-022 i_clear_cmd SHALL zero o_cycle_count in any state.
- Clear has priority over increment in the same cycle.
- The FSM transition on clear occurs only from HALTED.

Reset
REQ-023 Assertion of i_reset_n=0 SHALL immediately force state IDLE, which also forces o_step=0 immediately, including mid-RUN or mid-STEP.
REQ-024 While reset is asserted, all outputs SHALL be 0: o_state=00, o_step=0, o_halted=0, o_step_done=0, o_cycle_count=0; the burst counter SHALL be 0.
REQ-025 After deassertion, the first command SHALL be accepted on the first rising edge.

Configuration
REQ-026 With macro PIPELINE_STEP_CYCLE_COUNTER_EN defined, the 32-bit counter of REQ-021/022 SHALL be implemented.
REQ-027 Without it, o_cycle_count SHALL be constant 0, no counter flops SHALL exist, and all other behaviour SHALL be unchanged.

Verification
REQ-028 Run then stop: reset; pulse i_run_cmd; pulse i_stop_cmd 10 cycles later -> o_step high for 10 cycles, o_state back to 00, o_cycle_count=10.
REQ-029 Step burst: i_step_cmd with i_step_count=3 -> o_step high for exactly 3 cycles; o_step_done pulses once on the following cycle; with i_step_count=0 -> exactly 1 cycle.
REQ-030 Halt during run: RUN with i_halt_wb and i_stop_cmd both high on the same cycle -> o_state=11, o_halted=1, o_step=0; i_run_cmd ignored; i_clear_cmd -> IDLE, o_cycle_count=0.
REQ-031 Halt during step: i_step_count=5, i_halt_wb on the 2nd step cycle -> HALTED after 2 step cycles, no o_step_done.
REQ-032 Async reset mid-run: drop i_reset_n between clock edges during RUN -> o_step=0 before the next edge, all outputs 0.
REQ-033 Saturation (macro defined, counter preloaded via force to 0xFFFFFFFE): run 3 cycles -> o_cycle_count=0xFFFFFFFF; macro undefined -> o_cycle_count stays 0.
